// File: rtl/dmem_ctrl_pkg.sv
// Shared FSM encodings and RV32I load/store width codes for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_RD   = 2'd1,
        DMEM_ST_RESP = 2'd2
    } dmem_st_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Half-word accesses share the low Funct3 bits between signed and unsigned forms.
    function automatic logic is_half_access(input logic [2:0] funct3);
        return (funct3 == F3_LH) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the addressed byte/half out of a word and extends it per Funct3.
module dmem_load_align
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [15:0] shifted;

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        return 32'(b);
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        return 32'(h);
    endfunction

    // Word and unknown codes deliver the whole word as stored, ignoring the lane offset.
    always_comb begin
        shifted = 16'(word >> {off, 3'b000});
        data    = word;
        case (funct3)
            F3_LB:   data = sext8(shifted[7:0]);
            F3_LH:   data = sext16(shifted[15:0]);
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: one load/store at a time into a byte-strobed synchronous word array.
// Define DMEM_ERR_RESP_EN to flag misaligned and out-of-range accesses on Resp_Err.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_We,
    input  logic [31:0] Req_Addr,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_WData,
    input  logic [3:0]  Req_WStrb,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic [31:0] Resp_RData,
    output logic        Resp_Err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_st_e state, state_nxt;
    logic            accept;
    logic [1:0]      off;
    logic [AW-1:0]   idx;
    logic            req_err;
    logic [3:0]      estrb;
    logic [31:0]     wdata_sh;
    logic [31:0]     load_data;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     rd_word_p0;
    logic [1:0]      off_p0;
    logic [2:0]      f3_p0;
    logic            err_p0;

    assign off      = Req_Addr[1:0];
    assign idx      = Req_Addr[AW+1:2] - BASE_ADDR[AW+1:2];
    assign estrb    = Req_WStrb << off;
    assign wdata_sh = Req_WData << {off, 3'b000};

`ifdef DMEM_ERR_RESP_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic misalign;
    logic oor;

    always_comb begin
        misalign = (is_half_access(Req_Funct3) && off[0]) ||
                   ((Req_Funct3 == F3_LW) && (off != 2'b00));
        oor      = (Req_Addr < BASE_ADDR) ||
                   ({1'b0, Req_Addr - BASE_ADDR} >= SPAN);
        req_err  = misalign || oor;
    end
`else
    // Without error reporting, misaligned lanes are clipped and indices wrap.
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        Req_Ready  = 1'b0;
        Resp_Valid = 1'b0;
        accept     = 1'b0;
        case (state)
            DMEM_ST_IDLE: begin
                Req_Ready = !rst;
                accept    = Req_Valid && !rst;
                if (accept) begin
                    state_nxt = Req_We ? DMEM_ST_RESP : DMEM_ST_RD;
                end
            end
            DMEM_ST_RD: begin
                state_nxt = DMEM_ST_RESP;
            end
            DMEM_ST_RESP: begin
                Resp_Valid = 1'b1;
                if (Resp_Ready) begin
                    state_nxt = DMEM_ST_IDLE;
                end
            end
            default: state_nxt = DMEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DMEM_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: array write commits and read is issued at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && Req_We && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (estrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
        if (accept && !Req_We) begin
            rd_word_p0 <= mem[idx];
            off_p0     <= off;
            f3_p0      <= Req_Funct3;
            err_p0     <= req_err;
        end
    end

    dmem_load_align u_align (
        .word   (rd_word_p0),
        .off    (off_p0),
        .funct3 (f3_p0),
        .data   (load_data)
    );

    // Stage p1: response registers, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            Resp_RData <= 32'h0;
            Resp_Err   <= 1'b0;
        end else if (accept && Req_We) begin
            Resp_RData <= 32'h0;
            Resp_Err   <= req_err;
        end else if (state == DMEM_ST_RD) begin
            Resp_RData <= err_p0 ? 32'h0 : load_data;
            Resp_Err   <= err_p0;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized bench for dmem_ctrl against a byte-lane reference memory model.
module tb_dmem_ctrl;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_We;
    logic [31:0] Req_Addr;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_WData;
    logic [3:0]  Req_WStrb;
    logic        Resp_Valid;
    logic        Resp_Ready;
    logic [31:0] Resp_RData;
    logic        Resp_Err;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_We     (Req_We),
        .Req_Addr   (Req_Addr),
        .Req_Funct3 (Req_Funct3),
        .Req_WData  (Req_WData),
        .Req_WStrb  (Req_WStrb),
        .Resp_Valid (Resp_Valid),
        .Resp_Ready (Resp_Ready),
        .Resp_RData (Resp_RData),
        .Resp_Err   (Resp_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_idx(input logic [31:0] addr);
        return ((addr - BASE) >> 2) % DEPTH;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic [2:0] f3);
`ifdef DMEM_ERR_RESP_EN
        int unsigned o;
        o = addr % 4;
        if ((f3 == 3'd1 || f3 == 3'd5) && (o % 2 == 1)) return 1'b1;
        if (f3 == 3'd2 && o != 0) return 1'b1;
        if (addr < BASE) return 1'b1;
        if (((addr - BASE) >> 2) >= DEPTH) return 1'b1;
        return 1'b0;
`else
        return (addr === 32'hx) && (f3 === 3'hx);
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned o, b, h;
        logic [31:0] w;
        w = ref_mem[model_idx(addr)];
        o = addr % 4;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (8 * o)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        int unsigned ix, o;
        int lane;
        logic [31:0] w;
        ix = model_idx(addr);
        o  = addr % 4;
        w  = ref_mem[ix];
        for (int i = 0; i < 4; i++) begin
            lane = i - int'(o);
            if (lane >= 0 && strb[lane]) w[8*i +: 8] = wd[8*lane +: 8];
        end
        ref_mem[ix] = w;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [3:0] strb, input int hold,
                       output logic [31:0] got_d, output logic got_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          lat;
        exp_e = model_err(addr, f3);
        exp_d = (we || exp_e) ? 32'h0 : model_load(addr, f3);
        if (we && !exp_e) model_store(addr, wd, strb);

        @(negedge clk);
        Resp_Ready = (hold == 0);
        Req_Valid  = 1'b1;
        Req_We     = we;
        Req_Addr   = addr;
        Req_Funct3 = f3;
        Req_WData  = wd;
        Req_WStrb  = strb;
        chk("req_ready_idle", Req_Ready, 1);
        @(posedge clk);
        #1;
        Req_Valid  = 1'b0;
        Req_We     = 1'($urandom);
        Req_Addr   = $urandom;
        Req_Funct3 = 3'($urandom);
        Req_WData  = $urandom;
        Req_WStrb  = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Resp_Valid && lat < 10);
        chk(we ? "store_latency" : "load_latency", lat, we ? 1 : 2);
        chk("resp_rdata", Resp_RData, exp_d);
        chk("resp_err", Resp_Err, exp_e);
        got_d = Resp_RData;
        got_e = Resp_Err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", Resp_Valid, 1);
            chk("hold_rdata", Resp_RData, exp_d);
            chk("hold_err", Resp_Err, exp_e);
            chk("hold_req_ready", Req_Ready, 0);
        end
        Resp_Ready = 1'b1;
        @(negedge clk);
        chk("post_hs_ready", Req_Ready, 1);
        chk("post_hs_valid", Resp_Valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [3:0]  strb;
        int          sel;

        rst        = 1'b1;
        Req_Valid  = 1'b0;
        Req_We     = 1'b0;
        Req_Addr   = 32'h0;
        Req_Funct3 = 3'h0;
        Req_WData  = 32'h0;
        Req_WStrb  = 4'h0;
        Resp_Ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", Req_Ready, 0);
        chk("rst_resp_valid", Resp_Valid, 0);
        chk("rst_resp_rdata", Resp_RData, 32'h0);
        chk("rst_resp_err", Resp_Err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", Req_Ready, 1);

        for (int w = 0; w < 16; w++) begin
            txn(1'b1, 32'(4 * w), 3'd2, $urandom, 4'b1111, 0, d, e);
        end

        txn(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 4'b1111, 0, d, e);
        txn(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 0, d, e);
        chk("tp_lw_word", d, 32'hDEAD_BEEF);

        txn(1'b1, 32'h10, 3'd2, 32'h1122_3344, 4'b1111, 0, d, e);
        txn(1'b1, 32'h13, 3'd0, 32'h0000_00A5, 4'b0001, 0, d, e);
        txn(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 0, d, e);
        chk("tp_sb_word", d, 32'hA522_3344);
        txn(1'b0, 32'h13, 3'd0, 32'h0, 4'h0, 0, d, e);
        chk("tp_lb", d, 32'hFFFF_FFA5);
        txn(1'b0, 32'h13, 3'd4, 32'h0, 4'h0, 0, d, e);
        chk("tp_lbu", d, 32'h0000_00A5);

        txn(1'b1, 32'h20, 3'd2, 32'hCAFE_BABE, 4'b1111, 0, d, e);
        txn(1'b1, 32'h22, 3'd1, 32'h0000_8001, 4'b0011, 0, d, e);
        txn(1'b0, 32'h22, 3'd1, 32'h0, 4'h0, 0, d, e);
        chk("tp_lh", d, 32'hFFFF_8001);
        txn(1'b0, 32'h22, 3'd5, 32'h0, 4'h0, 0, d, e);
        chk("tp_lhu", d, 32'h0000_8001);
        txn(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 0, d, e);
        chk("tp_sh_lower_kept", d, 32'h8001_BABE);

        txn(1'b1, 32'h24, 3'd0, 32'h0000_00FF, 4'b0000, 0, d, e);
        chk("tp_nostrb_err", e, 0);

        txn(1'b0, 32'h21, 3'd2, 32'h0, 4'h0, 0, d, e);
`ifdef DMEM_ERR_RESP_EN
        chk("tp_mis_lw_err", e, 1);
        chk("tp_mis_lw_data", d, 32'h0);
`else
        chk("tp_mis_lw_err", e, 0);
        chk("tp_mis_lw_data", d, 32'h8001_BABE);
`endif
        txn(1'b1, 32'h23, 3'd1, 32'h0000_7777, 4'b0011, 0, d, e);
        txn(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 0, d, e);
`ifdef DMEM_ERR_RESP_EN
        chk("tp_mis_sh_unchanged", d, 32'h8001_BABE);
`else
        chk("tp_mis_sh_clipped", d, 32'h7701_BABE);
`endif

        txn(1'b0, 32'h400, 3'd2, 32'h0, 4'h0, 0, d, e);
        txn(1'b1, 32'h404, 3'd2, 32'h5555_AAAA, 4'b1111, 0, d, e);
        txn(1'b0, 32'h4, 3'd2, 32'h0, 4'h0, 0, d, e);

        txn(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 5, d, e);
        chk("tp_bp_data", d, 32'hA522_3344);

        // Reset while a load sits in RD.
        @(negedge clk);
        Req_Valid = 1'b1; Req_We = 1'b0; Req_Addr = 32'h10; Req_Funct3 = 3'd2;
        @(posedge clk);
        #1;
        Req_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rd_rst_valid", Resp_Valid, 0);
        chk("rd_rst_ready", Req_Ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rd_rst_ready_after", Req_Ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd_rst_no_valid", Resp_Valid, 0);
        end

        // Reset while a store response is pending; the write must survive.
        @(negedge clk);
        Resp_Ready = 1'b0;
        Req_Valid = 1'b1; Req_We = 1'b1; Req_Addr = 32'h30; Req_Funct3 = 3'd2;
        Req_WData = 32'h0BAD_F00D; Req_WStrb = 4'b1111;
        model_store(32'h30, 32'h0BAD_F00D, 4'b1111);
        @(posedge clk);
        #1;
        Req_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        Resp_Ready = 1'b1;
        #1;
        chk("resp_rst_valid", Resp_Valid, 0);
        chk("resp_rst_ready", Req_Ready, 1);
        txn(1'b0, 32'h30, 3'd2, 32'h0, 4'h0, 0, d, e);
        chk("resp_rst_store_kept", d, 32'h0BAD_F00D);

        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom);
            addr = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 63)
                                               : 32'($urandom_range(0, 63));
            if (we) begin
                sel  = $urandom_range(0, 2);
                f3   = 3'(sel);
                strb = (sel == 0) ? 4'b0001 : (sel == 1) ? 4'b0011 : 4'b1111;
                if ($urandom_range(0, 7) == 0) strb = 4'b0000;
            end else begin
                f3   = 3'($urandom_range(0, 7));
                strb = 4'b0000;
            end
            txn(we, addr, f3, $urandom, strb, $urandom_range(0, 2), d, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the core's load/store port; the memory-side consumer of the byte write strobes and Funct3 produced by the ALU control decode.
- Accepts one request at a time over a valid/ready handshake.
- Stores use lane-shifted byte strobes into a word-wide synchronous SRAM array. Loads return the extracted byte/half/word, sign- or zero-extended per Funct3.
- Sits between the MEM pipeline stage and the on-chip data RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block can accept a request.
- Req_We  in  1  1 = store, 0 = load.
- Req_Addr  in  32  byte address.
- Req_Funct3  in  3  load/store width code (RV32I encoding).
- Req_WData  in  32  store data, LSB-aligned.
- Req_WStrb  in  4  store strobe, LSB-aligned (0001 byte, 0011 half, 1111 word, 0000 none).
- Resp_Valid  out  1  response present.
- Resp_Ready  in  1  consumer takes response.
- Resp_RData  out  32  extended load data; 0 for stores and errors.
- Resp_Err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset: Req_Ready=0 during the reset cycle, then 1 (state IDLE). Resp_Valid=0, Resp_RData=0, Resp_Err=0. Array contents are not reset.
- FSM states: IDLE, RD, RESP.
  - IDLE: Req_Ready=1. Accept on Req_Valid&&Req_Ready at edge N.
  - Store accepted: the array is written at edge N. The state goes to RESP, so Resp_Valid=1 in cycle N+1.
  - Load accepted: the SRAM read is issued at edge N and the state goes to RD.
  - RD: at edge N+1, the formatted data is registered into Resp_RData and the state goes to RESP. Resp_Valid=1 in cycle N+2.
  - RESP: Resp_Valid, Resp_RData and Resp_Err are held stable until Resp_Valid&&Resp_Ready, then the state returns to IDLE. Req_Ready=0 in RD and RESP, so there is at most one outstanding request.
- Offset and word index:
  - off = Req_Addr[1:0].
  - Word index = (Req_Addr-BASE_ADDR)>>2.
- Store lane mapping:
  - Effective strobe = Req_WStrb<<off (4 bits).
  - Write data = Req_WData<<(8*off).
  - Only lanes whose effective strobe bit is 1 change.
  - Strobe 0000 gives a no-op store that still produces a response with Resp_Err=0.
- Load extraction, from the word shifted right by 8*off:
  - Funct3 000 (LB): sign-extend bit 7.
  - Funct3 001 (LH): sign-extend bit 15.
  - Funct3 010 (LW): full word.
  - Funct3 100 (LBU): zero-extend the byte.
  - Funct3 101 (LHU): zero-extend the half.
  - Other codes: return the full word.
- Error conditions:
  - Misaligned: half access with off[0]=1; word access with off!=0.
  - Out of range: address below BASE_ADDR, or word index >= DEPTH_WORDS.
  - On error there is no array write, Resp_RData=0 and Resp_Err=1. The latency is the same as the non-error case.
- Request fields are captured at accept. Changes to them after accept have no effect.
- Reset mid-operation (RD or RESP): the in-flight response is dropped and the FSM returns to IDLE. A store already committed at accept stays written.

Optional Feature:
- DMEM_ERR_RESP_EN defined: error detection as above.
- Undefined: Resp_Err is tied 0.
  - Misaligned accesses use the word at the truncated address with lanes clipped to bits 3:0 of the shifted strobe.
  - Out-of-range word indices wrap modulo DEPTH_WORDS.

Decomposition:
- SYSTEM_DEF.vh additions:
  - FSM state encodings: DMEM_ST_IDLE, DMEM_ST_RD, DMEM_ST_RESP.
  - Load Funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Strobe constants: STRB_B, STRB_H, STRB_W.
- One combinational sub-module, dmem_load_align: inputs are the word, off and Funct3; output is the extended data.
- Store lane shifting and the FSM stay in dmem_ctrl.

Test Plan:
- Word store: Addr=0x10, WData=0xDEADBEEF, Strb=1111, then LW 0x10 -> Resp_RData=0xDEADBEEF, Err=0, valid 2 cycles after accept.
- Byte store: SB 0xA5 to 0x13 over word 0x11223344, then LW 0x10 -> 0xA5223344. Then LB 0x13 -> 0xFFFFFFA5 and LBU 0x13 -> 0x000000A5.
- Half store: SH 0x8001 to 0x22, then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001. The lower half of word 0x20 is unchanged.
- Misaligned: LW 0x21 and SH 0x23 -> Err=1, RData=0, memory unchanged.
  - With DMEM_ERR_RESP_EN undefined: Err=0 and LW 0x21 returns word 0x20.
- Backpressure: hold Resp_Ready=0 for 5 cycles after a load response -> Resp_Valid, RData and Err stay stable and Req_Ready=0 throughout; accept resumes the cycle after the Resp_Ready handshake.
- Reset in RD: assert rst one cycle after a load accept -> Resp_Valid never rises; Req_Ready=1 the cycle after rst deasserts.
